// File: rtl/mul_datapath_if.sv
// Result port of the sequential multiplier datapath: held product with a valid/ready handshake.
// The datapath drives it through the master modport; the consumer uses the slave modport.
interface mul_datapath_if #(
  parameter int WIDTH = 8
);
  logic [2*WIDTH-1:0] product;
  logic               result_valid;
  logic               result_ready;

  modport master (
    output product,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  product,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/mul_datapath.sv
// Shift-add datapath of the unsigned sequential multiplier. It follows the FSM's registered state code,
// feeds the live multiplier LSB back to the FSM and hands the finished product out over a valid/ready port.
module mul_datapath #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [1:0]        state,
  input  logic [WIDTH-1:0]  multiplicand_in,
  input  logic [WIDTH-1:0]  multiplier_in,
  output logic [WIDTH-1:0]  multiplier,
  mul_datapath_if.master    result,
  output logic              result_ovf,
  output logic              step_err
);

  localparam int SW = $clog2(WIDTH + 1) + 1;
  localparam logic [SW-1:0] STEP_LIMIT = SW'(WIDTH);
  localparam logic [SW-1:0] STEP_SAT   = SW'(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_EXEC = 2'd1,
    ST_IDLE = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             carry;
  logic [SW-1:0]    steps;
  logic             armed;
  logic [WIDTH:0]   sum;

  assign sum        = {1'b0, acc_hi} + {1'b0, mcand};
  assign multiplier = acc_lo;

  // NOTE: all state below is sequential, so every assignment is non-blocking; reads see pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mcand               <= '0;
      acc_hi              <= '0;
      acc_lo              <= '0;
      carry               <= 1'b0;
      steps               <= '0;
      armed               <= 1'b0;
      step_err            <= 1'b0;
      result_ovf          <= 1'b0;
      result.product      <= '0;
      result.result_valid <= 1'b0;
    end else begin
      // Consumption by default; a capture on the same edge overrides it below.
      if (result.result_valid && result.result_ready) begin
        result.result_valid <= 1'b0;
      end

      case (state)
        ST_INIT: begin
          mcand    <= multiplicand_in;
          acc_lo   <= multiplier_in;
          acc_hi   <= '0;
          carry    <= 1'b0;
          steps    <= '0;
          armed    <= 1'b1;
          step_err <= 1'b0;
        end
        ST_EXEC: begin
          // {0, c, s, acc_lo} >> 1: the add carry lands in the MSB of acc_hi.
          carry  <= 1'b0;
          acc_hi <= sum[WIDTH:1];
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
          if (steps == STEP_LIMIT) step_err <= 1'b1;
          if (steps != STEP_SAT)   steps    <= steps + SW'(1);
        end
        ST_IDLE: begin
          carry  <= 1'b0;
          acc_hi <= {carry, acc_hi[WIDTH-1:1]};
          acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
          if (steps == STEP_LIMIT) step_err <= 1'b1;
          if (steps != STEP_SAT)   steps    <= steps + SW'(1);
        end
        ST_HALT: begin
          if (armed) begin
            result.product      <= {acc_hi, acc_lo};
            result.result_valid <= 1'b1;
            armed               <= 1'b0;
            if (result.result_valid && !result.result_ready) result_ovf <= 1'b1;
          end
        end
        // Unknown state codes hold everything and never capture.
        default: ;
      endcase
    end
  end

endmodule
